// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the data port and the shared memory port that
// the arbiter sits between. The slave modport is the arbiter's view; the
// master modport is the view of the requesters/memory driving it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction fetch side
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_flush;
    logic                  if_ack;
    logic [DATA_W-1:0]     if_rdata;

    // Load/store side
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_wstrb;
    logic                  dm_ack;
    logic [DATA_W-1:0]     dm_rdata;

    // Pipeline freeze controls
    logic                  stall_if;
    logic                  stall_mem;

    // Unified memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_ack, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_ack, dm_rdata,
        output stall_if, stall_mem,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_ack, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_ack, dm_rdata,
        input  stall_if, stall_mem,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Data wins arbitration unless fetch has lost STARVE_MAX times in a row.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);
    localparam int SW = DATA_W / 8;
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_owner_if;
    logic               r_kill;
    logic [CW-1:0]      r_starve;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [SW-1:0]      r_mem_wstrb;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_dm_rdata;

    logic               w_fetch_elig;
    logic               w_pick_dm;
    logic               w_pick_if;
    logic               w_kill_now;
    logic               w_if_ack;
    logic               w_dm_ack;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Arbitration, next-state selection and the ack pulses
    always_comb begin
        w_state_nxt  = r_state;
        w_pick_dm    = 1'b0;
        w_pick_if    = 1'b0;
        w_if_ack     = 1'b0;
        w_dm_ack     = 1'b0;
        w_kill_now   = r_kill;
        w_fetch_elig = bus.if_req & ~bus.if_flush;
        case (r_state)
            S_IDLE: begin
                if (bus.dm_req && !(w_fetch_elig && r_starve == STARVE_TOP)) begin
                    w_pick_dm   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (w_fetch_elig) begin
                    w_pick_if   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A flush while the fetch is in flight poisons its response
                w_kill_now = r_kill | (r_owner_if & bus.if_flush);
                if (bus.mem_gnt) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_kill_now = r_kill | (r_owner_if & bus.if_flush);
                if (bus.mem_rvalid) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_if_ack    = r_owner_if & ~r_kill & ~bus.if_flush;
                w_dm_ack    = ~r_owner_if;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Count consecutive fetch losses; a fetch win resets the count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_pick_if) begin
            r_starve <= '0;
        end else if (w_pick_dm && w_fetch_elig && r_starve != STARVE_TOP) begin
            r_starve <= r_starve + CW'(1);
        end
    end

    // Latch the winner's transaction fields and track the kill flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_if  <= 1'b0;
            r_kill      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            if (w_pick_dm) begin
                r_owner_if  <= 1'b0;
                r_mem_we    <= bus.dm_we;
                r_mem_addr  <= bus.dm_addr;
                r_mem_wdata <= bus.dm_wdata;
                r_mem_wstrb <= bus.dm_wstrb;
            end else if (w_pick_if) begin
                r_owner_if  <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= bus.if_addr;
                r_mem_wdata <= '0;
                r_mem_wstrb <= '0;
            end
            r_kill <= (w_state_nxt == S_IDLE) ? 1'b0 : w_kill_now;
        end
    end

    // Capture read data for the owner; killed fetches and stores leave it alone
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (r_state == S_WAIT && bus.mem_rvalid) begin
            if (r_owner_if) begin
                if (!w_kill_now) r_if_rdata <= bus.mem_rdata;
            end else if (!r_mem_we) begin
                r_dm_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_ack    = w_if_ack;
    assign bus.dm_ack    = w_dm_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.stall_if  = bus.if_req & ~w_if_ack & ~bus.if_flush;
    assign bus.stall_mem = bus.dm_req & ~w_dm_ack;
    assign bus.mem_req   = (r_state == S_ISSUE);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: an order-of-service model predicts
// the memory transactions and acks; a memory responder and an ack monitor
// pop and compare independently of the stimulus.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        is_if;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    typedef struct packed {
        logic        is_if;
        logic [31:0] data;
    } ack_t;

    txn_t q_txn[$];
    ack_t q_ack[$];

    int checks   = 0;
    int failures = 0;
    int lat_mode = 0;   // 0 random latency, 1 immediate, 2 immediate gnt + slow rvalid

    // Reference model state
    int          m_starve = 0;
    logic [31:0] m_if = '0;
    logic [31:0] m_dm = '0;

    // Stimulus operands for a burst
    logic        op_we    [8];
    logic [31:0] op_addr  [8];
    logic [31:0] op_wdata [8];
    logic [3:0]  op_wstrb [8];
    logic [31:0] f_addr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: grants, checks the issued fields, returns data
    initial begin
        int          ph;
        int          cnt;
        int          tgt;
        logic        r_we;
        logic [31:0] r_addr;
        txn_t        t;
        ph = 0; cnt = 0; tgt = 0; r_we = 1'b0; r_addr = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (ph == 0) begin
                if (bus.mem_req && !reset) begin
                    if (cnt == 0) tgt = (lat_mode == 0) ? int'($urandom_range(0, 2)) : 0;
                    if (cnt >= tgt) begin
                        bus.mem_gnt = 1'b1;
                        r_we   = bus.mem_we;
                        r_addr = bus.mem_addr;
                        if (q_txn.size() == 0) begin
                            chk("unexpected_txn", {bus.mem_we, bus.mem_addr}, 0);
                        end else begin
                            t = q_txn.pop_front();
                            if (t.is_if)
                                chk("txn_fetch", {bus.mem_we, bus.mem_addr, bus.mem_wstrb},
                                    {1'b0, t.addr, 4'h0});
                            else
                                chk("txn_data", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb},
                                    {t.we, t.addr, t.wdata, t.wstrb});
                        end
                        ph  = 1;
                        cnt = 0;
                        tgt = (lat_mode == 0) ? int'($urandom_range(0, 2)) : ((lat_mode == 2) ? 3 : 0);
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                if (cnt >= tgt) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = r_we ? $urandom() : mdata(r_addr);
                    ph  = 0;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Ack monitor and stall relations, sampled mid-cycle
    ack_t e;
    always @(negedge clk) begin
        if (!reset) begin
            chk("stall_if", bus.stall_if, bus.if_req & ~bus.if_ack & ~bus.if_flush);
            chk("stall_mem", bus.stall_mem, bus.dm_req & ~bus.dm_ack);
            if (bus.if_ack || bus.dm_ack) begin
                chk("ack_exclusive", bus.if_ack & bus.dm_ack, 0);
                if (q_ack.size() == 0) begin
                    chk("unexpected_ack", {bus.if_ack, bus.dm_ack}, 0);
                end else begin
                    e = q_ack.pop_front();
                    chk("ack_owner", bus.if_ack, e.is_if);
                    chk(e.is_if ? "if_rdata" : "dm_rdata",
                        e.is_if ? bus.if_rdata : bus.dm_rdata, e.data);
                end
            end
        end
    end

    task automatic push_fetch(input logic [31:0] a, input bit with_ack);
        txn_t t;
        ack_t k;
        t = '{is_if: 1'b1, we: 1'b0, addr: a, wdata: '0, wstrb: '0};
        q_txn.push_back(t);
        m_starve = 0;
        if (with_ack) begin
            m_if = mdata(a);
            k = '{is_if: 1'b1, data: m_if};
            q_ack.push_back(k);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ctrl"}, {bus.if_ack, bus.dm_ack, bus.stall_if, bus.stall_mem,
                             bus.mem_req, bus.mem_we, bus.mem_wstrb}, 0);
        chk({tag, "_data"}, {bus.if_rdata, bus.dm_rdata, bus.mem_addr}, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
    endtask

    // k data ops plus an optional fetch, all presented together
    task automatic run_burst(input int k, input bit f, input bit drop_early);
        int   di;
        bit   fp;
        bit   fdone;
        bit   drop;
        bit   saw_dm;
        bit   saw_if;
        int   cyc;
        txn_t t;
        ack_t a;
        // Order of service from the arbitration rules
        di = 0; fp = f;
        while (di < k || fp) begin
            if (di < k && !(fp && m_starve == STARVE_MAX)) begin
                t = '{is_if: 1'b0, we: op_we[di], addr: op_addr[di],
                      wdata: op_wdata[di], wstrb: op_wstrb[di]};
                q_txn.push_back(t);
                if (!op_we[di]) m_dm = mdata(op_addr[di]);
                a = '{is_if: 1'b0, data: m_dm};
                q_ack.push_back(a);
                if (fp && m_starve < STARVE_MAX) m_starve++;
                di++;
            end else begin
                push_fetch(f_addr, 1'b1);
                fp = 1'b0;
            end
        end
        // Drive
        @(posedge clk); #1;
        di = 0; fdone = !f; drop = 1'b0; cyc = 0;
        bus.if_req  = f;
        bus.if_addr = f_addr;
        if (k > 0) begin
            bus.dm_req = 1'b1; bus.dm_we = op_we[0]; bus.dm_addr = op_addr[0];
            bus.dm_wdata = op_wdata[0]; bus.dm_wstrb = op_wstrb[0];
        end
        while (di < k || !fdone) begin
            @(negedge clk);
            saw_dm = bus.dm_ack;
            saw_if = bus.if_ack;
            if (drop_early && bus.mem_req) drop = 1'b1;
            @(posedge clk); #1;
            if (saw_dm) di++;
            if (saw_if) begin fdone = 1'b1; bus.if_req = 1'b0; end
            if (di < k && !drop) begin
                bus.dm_req = 1'b1; bus.dm_we = op_we[di]; bus.dm_addr = op_addr[di];
                bus.dm_wdata = op_wdata[di]; bus.dm_wstrb = op_wstrb[di];
            end else begin
                bus.dm_req = 1'b0;
            end
            cyc++;
            if (cyc > 300) begin
                chk("burst_timeout", cyc, 0);
                q_txn.delete();
                q_ack.delete();
                break;
            end
        end
        bus.dm_req = 1'b0;
        bus.if_req = 1'b0;
        chk("queues_drained", {q_ack.size(), q_txn.size()}, 0);
    endtask

    task automatic wait_grant(input string tag);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.mem_gnt && bus.mem_req) && cyc < 30);
        if (cyc >= 30) chk({tag, "_grant_timeout"}, cyc, 0);
    endtask

    // Fetch at 0x40 with an immediate memory: mem_req at N+1, ack at N+3
    task automatic test_latency();
        lat_mode = 1;
        @(posedge clk); #1;
        push_fetch(32'h0000_0040, 1'b1);
        bus.if_addr = 32'h0000_0040;
        bus.if_req  = 1'b1;
        @(posedge clk); #1;
        chk("lat_mem_req_n1", bus.mem_req, 1);
        @(posedge clk); #1;
        chk("lat_wait_n2", {bus.mem_req, bus.if_ack}, 0);
        @(posedge clk); #1;
        chk("lat_if_ack_n3", bus.if_ack, 1);
        chk("lat_if_rdata", bus.if_rdata, 32'h0050_0093);
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        chk("lat_drained", {q_ack.size(), q_txn.size()}, 0);
        lat_mode = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0;
        bus.dm_wdata = '0; bus.dm_wstrb = '0;
        f_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        reset = 1'b0;

        // Plain fetch timing
        test_latency();

        // Collision: load 0x100 beats the fetch, fetch follows
        op_we[0] = 1'b0; op_addr[0] = 32'h100; op_wdata[0] = '0; op_wstrb[0] = '0;
        f_addr = 32'h80;
        run_burst(1, 1'b1, 1'b0);

        // Starvation: six back-to-back loads, fetch must slip in after four
        for (int i = 0; i < 6; i++) begin
            op_we[i] = 1'b0; op_addr[i] = 32'h300 + 32'(4 * i);
            op_wdata[i] = $urandom(); op_wstrb[i] = 4'hF;
        end
        f_addr = 32'hC0;
        run_burst(6, 1'b1, 1'b0);

        // Store: fields reach memory, dm_rdata keeps the last load value
        op_we[0] = 1'b1; op_addr[0] = 32'h200; op_wdata[0] = 32'hDEAD_BEEF; op_wstrb[0] = 4'b0011;
        run_burst(1, 1'b0, 1'b0);

        // Load whose requester drops dm_req once issued still gets its ack
        op_we[0] = 1'b0; op_addr[0] = 32'h404; op_wdata[0] = '0; op_wstrb[0] = '0;
        run_burst(1, 1'b0, 1'b1);

        // Flush during WAIT: txn completes silently, if_rdata held
        lat_mode = 2;
        @(posedge clk); #1;
        push_fetch(32'h0000_0500, 1'b0);
        bus.if_addr = 32'h0000_0500;
        bus.if_req  = 1'b1;
        wait_grant("flush");
        @(posedge clk); #1;
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
        @(posedge clk); #1;
        bus.if_flush = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("flush_if_rdata_held", bus.if_rdata, m_if);
        chk("flush_drained", {q_ack.size(), q_txn.size()}, 0);
        lat_mode = 0;
        f_addr = 32'h0000_0504;
        run_burst(0, 1'b1, 1'b0);

        // Reset in WAIT, stale rvalid lands in IDLE
        lat_mode = 2;
        @(posedge clk); #1;
        push_fetch(32'h0000_0600, 1'b0);
        bus.if_addr = 32'h0000_0600;
        bus.if_req  = 1'b1;
        wait_grant("rst");
        @(posedge clk); #1;
        reset      = 1'b1;
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_zero_outputs("reset_mid_txn");
        m_if = '0; m_dm = '0; m_starve = 0;
        repeat (6) @(posedge clk);
        #1;
        check_zero_outputs("stale_rvalid");
        chk("rst_drained", {q_ack.size(), q_txn.size()}, 0);
        test_latency();

        // Randomised bursts
        for (int r = 0; r < 30; r++) begin
            int  k;
            bit  f;
            k = $urandom_range(0, 6);
            f = 1'($urandom_range(0, 1));
            if (k == 0) f = 1'b1;
            for (int i = 0; i < k; i++) begin
                op_we[i]    = 1'($urandom_range(0, 1));
                op_addr[i]  = $urandom() & 32'hFFFF_FFFC;
                op_wdata[i] = $urandom();
                op_wstrb[i] = 4'($urandom_range(0, 15));
            end
            f_addr = $urandom() & 32'hFFFF_FFFC;
            run_burst(k, f, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
